// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain initiator: serialises host words onto ccff_head, optionally re-streams them
// to compare ccff_tail, and holds IO isolation until a load finishes.
`timescale 1ns/1ps
module ccff_bitstream_loader #(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1),
    parameter int unsigned ERR_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset_N,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              IO_ISOL_N,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ERR_W-1:0]  err_count
);

    localparam int unsigned        BufCntW = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]   LastBit = CNT_W'(CHAIN_LEN - 1);
    localparam logic [ERR_W-1:0]   ErrMax  = '1;

    typedef enum logic [1:0] {StIdle, StLoad, StVerify, StDone} state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   buf_data_q, buf_data_d;
    logic [BufCntW-1:0]  buf_cnt_q, buf_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                verify_q, verify_d;
    logic                head_q, head_d;
    logic                shift_en_q, shift_en_d;
    logic                cmp_q, cmp_d;
    logic                drain_q, drain_d;
    logic                isol_n_q, isol_n_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;

    logic active, buf_empty, shifting, pass_end, last_pass, accept, mismatch;

    always_comb begin
        // drain_q marks the extra cycle that scores the final verify bit before DONE
        active    = (state_q == StLoad || state_q == StVerify) && !drain_q;
        buf_empty = (buf_cnt_q == '0);
        shifting  = active && !buf_empty;
        pass_end  = shifting && (bit_cnt_q == LastBit);
        last_pass = (state_q == StVerify) || !verify_q;
        // no word is taken on the final edge of the last pass: it would be lost
        cfg_ready = active && (buf_empty || (buf_cnt_q == BufCntW'(1) && shifting))
                    && !(pass_end && last_pass);
        accept    = cfg_valid && cfg_ready;
        // cmp_q flags that the bit on ccff_head belongs to the verify stream
        mismatch  = ccff_shift_en && cmp_q && (ccff_tail != head_q);
    end

    always_comb begin
        state_d    = state_q;
        buf_data_d = buf_data_q;
        buf_cnt_d  = buf_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        verify_d   = verify_q;
        head_d     = head_q;
        shift_en_d = shifting;
        cmp_d      = shifting && (state_q == StVerify);
        drain_d    = 1'b0;
        isol_n_d   = isol_n_q;
        done_d     = done_q;
        error_d    = error_q;
        err_cnt_d  = err_cnt_q;

        if (shifting) begin
            head_d     = buf_data_q[WORD_W-1];
            buf_data_d = buf_data_q << 1;
            buf_cnt_d  = buf_cnt_q - BufCntW'(1);
            bit_cnt_d  = pass_end ? '0 : bit_cnt_q + CNT_W'(1);
        end
        if (pass_end) begin
            buf_cnt_d = '0;
        end
        if (accept) begin
            buf_data_d = cfg_data;
            buf_cnt_d  = BufCntW'(WORD_W);
        end
        if (mismatch) begin
            error_d = 1'b1;
            if (err_cnt_q != ErrMax) begin
                err_cnt_d = err_cnt_q + ERR_W'(1);
            end
        end

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StLoad;
                    verify_d  = verify_en;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    err_cnt_d = '0;
                    bit_cnt_d = '0;
                    buf_cnt_d = '0;
                    isol_n_d  = 1'b0;
                end
            end
            StLoad: begin
                if (pass_end) begin
                    if (verify_q) begin
                        state_d = StVerify;
                    end else begin
                        state_d  = StDone;
                        done_d   = 1'b1;
                        isol_n_d = 1'b1;
                    end
                end
            end
            StVerify: begin
                if (drain_q) begin
                    state_d  = StDone;
                    done_d   = 1'b1;
                    isol_n_d = 1'b1;
                end else if (pass_end) begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge prog_clk or negedge pReset_N) begin
        if (!pReset_N) begin
            state_q    <= StIdle;
            buf_data_q <= '0;
            buf_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            verify_q   <= 1'b0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b0;
            cmp_q      <= 1'b0;
            drain_q    <= 1'b0;
            isol_n_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            buf_data_q <= buf_data_d;
            buf_cnt_q  <= buf_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            verify_q   <= verify_d;
            head_q     <= head_d;
            shift_en_q <= shift_en_d;
            cmp_q      <= cmp_d;
            drain_q    <= drain_d;
            isol_n_q   <= isol_n_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign IO_ISOL_N     = isol_n_q;
    assign busy          = (state_q == StLoad) || (state_q == StVerify);
    assign done          = done_q;
    assign error         = error_q;
    assign err_count     = err_cnt_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader against a 12-flop behavioural chain.
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

    localparam int unsigned CHAIN_LEN = 12;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned ERR_W     = 16;

    logic              prog_clk  = 1'b0;
    logic              pReset_N  = 1'b0;
    logic              start     = 1'b0;
    logic              verify_en = 1'b0;
    logic [WORD_W-1:0] cfg_data  = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready, ccff_head, ccff_shift_en, ccff_tail;
    logic              IO_ISOL_N, busy, done, error;
    logic [ERR_W-1:0]  err_count;

    logic [CHAIN_LEN-1:0] chain = '0;
    int                   chain_shifts = 0;
    logic                 inv_en = 1'b0;
    int                   inv_at = 0;

    ccff_bitstream_loader #(
        .CHAIN_LEN(CHAIN_LEN),
        .WORD_W   (WORD_W),
        .ERR_W    (ERR_W)
    ) dut (
        .prog_clk     (prog_clk),
        .pReset_N     (pReset_N),
        .start        (start),
        .verify_en    (verify_en),
        .cfg_data     (cfg_data),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
        .IO_ISOL_N    (IO_ISOL_N),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_count    (err_count)
    );

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (ccff_shift_en) begin
            chain        <= {chain[CHAIN_LEN-2:0], ccff_head};
            chain_shifts <= chain_shifts + 1;
        end
    end

    assign ccff_tail = chain[CHAIN_LEN-1] ^ (inv_en && (chain_shifts == inv_at));

    // Scoreboard queues filled by the stimulus thread
    bit          exp_head[$];
    int          exp_done_shifts[$];
    int          exp_done_err[$];
    int          snap_sel[$];
    logic [31:0] snap_val[$];
    string       snap_name[$];
    bit          finish_req = 1'b0;

    int   checks = 0;
    int   errors = 0;
    logic busy_p = 1'b0, done_p = 1'b0, isol_p = 1'b0;
    int   op_shifts = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] probe(input int sel);
        case (sel)
            0:       return 32'(cfg_ready);
            1:       return 32'(ccff_head);
            2:       return 32'(ccff_shift_en);
            3:       return 32'(IO_ISOL_N);
            4:       return 32'(busy);
            5:       return 32'(done);
            6:       return 32'(error);
            7:       return 32'(err_count);
            default: return 32'(chain);
        endcase
    endfunction

    // Monitor: all comparisons happen here, on the falling edge
    always @(negedge prog_clk) begin
        while (snap_sel.size() > 0) begin
            int          s;
            logic [31:0] v;
            string       nm;
            s  = snap_sel.pop_front();
            v  = snap_val.pop_front();
            nm = snap_name.pop_front();
            if (s == 8) begin
                checks++;
                errors++;
                $display("FAIL %s: wait expired, got nothing expected event", nm);
            end else begin
                chk(nm, probe(s), v);
            end
        end
        if (busy && !busy_p) op_shifts = 0;
        if (ccff_shift_en === 1'b1) begin
            op_shifts++;
            if (exp_head.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_extra: got shift of %0b expected no shift", ccff_head);
            end else begin
                chk("head", 32'(ccff_head), 32'(exp_head.pop_front()));
            end
        end
        if (done && !done_p) begin
            if (exp_done_shifts.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_extra: got done expected none");
            end else begin
                int es;
                int ee;
                es = exp_done_shifts.pop_front();
                ee = exp_done_err.pop_front();
                chk("shift_count", 32'(op_shifts), 32'(es));
                chk("err_count_at_done", 32'(err_count), 32'(ee));
                chk("error_at_done", 32'(error), (ee != 0) ? 32'd1 : 32'd0);
                chk("isol_at_done", 32'(IO_ISOL_N), 32'd1);
                chk("isol_before_done", 32'(isol_p), 32'd0);
            end
        end
        busy_p = busy;
        done_p = done;
        isol_p = IO_ISOL_N;
        if (finish_req) begin
            chk("head_left", 32'(exp_head.size()), 32'd0);
            chk("done_left", 32'(exp_done_shifts.size()), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    task automatic snap(input int sel, input logic [31:0] v, input string nm);
        snap_sel.push_back(sel);
        snap_val.push_back(v);
        snap_name.push_back(nm);
    endtask

    task automatic push_pass();
        logic [15:0] s;
        s = 16'hA53F;
        for (int i = 0; i < CHAIN_LEN; i++) exp_head.push_back(s[15-i]);
    endtask

    task automatic expect_done(input int shifts, input int err);
        exp_done_shifts.push_back(shifts);
        exp_done_err.push_back(err);
    endtask

    task automatic pulse_start(input logic v);
        start     = 1'b1;
        verify_en = v;
        tick();
        start     = 1'b0;
        verify_en = 1'b0;
    endtask

    task automatic send(input logic [WORD_W-1:0] w);
        int n;
        n         = 0;
        cfg_valid = 1'b1;
        cfg_data  = w;
        while (!cfg_ready && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) snap(8, 0, "send_ready");
        tick();
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        if (!done) snap(8, 0, nm);
    endtask

    task automatic send_stream(input int passes);
        for (int p = 0; p < passes; p++) begin
            send(8'hA5);
            send(8'h3F);
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        for (int s = 0; s < 8; s++) snap(s, 0, "reset_value");
        tick();
        pReset_N = 1'b1;
        tick();

        // Plain load, valid held high
        expect_done(12, 0);
        push_pass();
        pulse_start(1'b0);
        send_stream(1);
        wait_done("t1_done");
        tick();
        snap(9, 32'hA53, "t1_chain");
        snap(2, 0, "t1_shift_stopped");
        repeat (3) tick();

        // Load plus clean verify
        expect_done(24, 0);
        push_pass();
        push_pass();
        pulse_start(1'b1);
        send_stream(2);
        wait_done("t2_done");
        tick();
        snap(9, 32'hA53, "t2_chain");
        snap(6, 0, "t2_error");
        snap(7, 0, "t2_err_count");
        repeat (3) tick();

        // Verify with verify bit 5 seeing an inverted tail
        inv_at = chain_shifts + CHAIN_LEN + 5;
        inv_en = 1'b1;
        expect_done(24, 1);
        push_pass();
        push_pass();
        pulse_start(1'b1);
        send_stream(2);
        wait_done("t3_done");
        tick();
        inv_en = 1'b0;
        snap(6, 1, "t3_error");
        snap(7, 1, "t3_err_count");
        snap(5, 1, "t3_done_held");
        repeat (3) tick();

        // Restart from DONE clears status; start mid-load is ignored
        expect_done(12, 0);
        push_pass();
        pulse_start(1'b0);
        snap(3, 0, "t6_isol_dropped");
        snap(7, 0, "t6_err_cleared");
        snap(6, 0, "t6_error_cleared");
        snap(5, 0, "t6_done_cleared");
        snap(4, 1, "t6_busy");
        send(8'hA5);
        cfg_data = 8'h3F;
        pulse_start(1'b1);
        snap(4, 1, "t6_busy_after_ignored_start");
        snap(5, 0, "t6_not_done");
        send(8'h3F);
        cfg_valid = 1'b0;
        wait_done("t6_done");
        tick();
        snap(9, 32'hA53, "t6_chain");
        repeat (3) tick();

        // Gaps: stall the chain for the cycles the buffer is empty
        expect_done(12, 0);
        push_pass();
        pulse_start(1'b0);
        send(8'hA5);
        cfg_valid = 1'b0;
        n = 0;
        while (!cfg_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cfg_ready) snap(8, 0, "t4_ready");
        tick();
        tick();
        snap(2, 0, "t4_gap_stall_a");
        tick();
        snap(2, 0, "t4_gap_stall_b");
        send(8'h3F);
        cfg_valid = 1'b0;
        wait_done("t4_done");
        tick();
        snap(9, 32'hA53, "t4_chain");
        repeat (3) tick();

        // Reset during the 7th load shift, then a fresh load
        expect_done(12, 0);
        push_pass();
        pulse_start(1'b0);
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        n = 0;
        for (int i = 0; i < 60 && n < 7; i++) begin
            tick();
            if (ccff_shift_en) n++;
        end
        if (n < 7) snap(8, 0, "t5_shift7");
        pReset_N = 1'b0;
        exp_head.delete();
        exp_done_shifts.delete();
        exp_done_err.delete();
        for (int s = 0; s < 8; s++) snap(s, 0, "t5_async_reset");
        tick();
        tick();
        cfg_valid = 1'b0;
        pReset_N  = 1'b1;
        tick();
        expect_done(12, 0);
        push_pass();
        pulse_start(1'b0);
        send_stream(1);
        wait_done("t5_done");
        tick();
        snap(9, 32'hA53, "t5_chain");
        repeat (3) tick();

        finish_req = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected summary");
        $fatal(1, "simulation time limit reached");
    end

endmodule

// File: doc/ccff_bitstream_loader.md
Name: ccff_bitstream_loader

Overview:
- Initiator end of the configuration chain: serialises a host-supplied bitstream onto `ccff_head` and qualifies each chain shift with `ccff_shift_en`.
- Optional verify pass: the host streams the bitstream a second time and the block compares `ccff_tail` against it bit by bit.
- Holds IO isolation (`IO_ISOL_N`) low until a load completes; sits between the SoC config port and the fabric's head/tail chain ports.

Parameters:
- CHAIN_LEN, 1024, number of configuration flops in the chain (≥2).
- WORD_W, 8, host word width in bits.
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit-position counter.
- ERR_W, 16, width of the saturating mismatch counter.

Ports:
- prog_clk  in  1  single clock; chain and block both sample on the rising edge.
- pReset_N  in  1  asynchronous active-low reset.
- start  in  1  1-cycle pulse; begins a load; ignored while busy.
- verify_en  in  1  sampled with start; 1 = load pass followed by verify pass.
- cfg_data  in  WORD_W  bitstream word, MSB shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted on an edge where valid&&ready.
- ccff_head  out  1  serial bit into the chain (registered).
- ccff_shift_en  out  1  chain advances only on edges ending cycles with this high (registered; gates the fabric prog clock).
- ccff_tail  in  1  serial bit out of the chain.
- IO_ISOL_N  out  1  0 = IOs isolated.
- busy  out  1  in LOAD or VERIFY.
- done  out  1  level; load (and verify, if enabled) finished.
- error  out  1  level; at least one verify mismatch.
- err_count  out  ERR_W  mismatch count, saturates at all-ones.

Behaviour:
- Reset values: cfg_ready=0, ccff_head=0, ccff_shift_en=0, IO_ISOL_N=0, busy=0, done=0, error=0, err_count=0, FSM=IDLE, word buffer empty, bit counter 0.
- FSM states IDLE, LOAD, VERIFY, DONE.
  - IDLE/DONE + start → LOAD. On entry: latch verify_en; clear done, error, err_count and the bit counter; drive IO_ISOL_N=0.
  - LOAD → VERIFY when the bit counter reaches CHAIN_LEN and verify latched; otherwise LOAD → DONE.
  - VERIFY → DONE when the bit counter reaches CHAIN_LEN.
  - In DONE: IO_ISOL_N=1 the same edge done rises; IO_ISOL_N stays 1 until the next start.
- Word buffer:
  - Holds WORD_W bits plus a remaining-bit count.
  - cfg_ready=1 in LOAD/VERIFY when the buffer holds 0 bits, or holds 1 bit that is shifting this cycle. This sustains 1 bit/cycle.
  - On accept, the word loads on the same edge as that last bit shifts.
- Shifting: on each LOAD/VERIFY cycle with a non-empty buffer, the MSB moves to ccff_head and ccff_shift_en is set for the next cycle. The bit counter increments per shifted bit.
- Stalls: an empty buffer drives ccff_shift_en=0 the next cycle and the chain holds. ccff_head holds its last value.
- Pass boundary: when the counter hits CHAIN_LEN, unshifted buffer bits are discarded and the counter resets to 0. Each pass starts on a word boundary; the host pads the final word of each pass.
- Verify compare:
  - Occurs in each cycle where ccff_shift_en=1 during the verify pass, before the edge.
  - Verify bit k is on ccff_head, and ccff_tail must equal it (load bit k reached the tail after CHAIN_LEN-1 further shifts).
  - Mismatch: error=1, err_count+1 saturating.
  - The final compare is counted before DONE is entered.
- start while busy: ignored. cfg_valid outside LOAD/VERIFY: ignored, ready=0.
- pReset_N asserted mid-operation: immediate return to reset values, IO_ISOL_N=0. Chain contents are undefined; a new start is required.

Test Plan:
- CHAIN_LEN=12, WORD_W=8, verify_en=0; words 0xA5, 0x3F with valid held high → head sequence 1,0,1,0,0,1,0,1,0,0,1,1, exactly 12 shift_en cycles, low 4 bits of 0x3F discarded; done=1 and IO_ISOL_N=1 on the same edge.
- Same load with verify_en=1 against a 12-flop behavioural chain; stream is sent twice → 24 shift cycles, error=0, err_count=0, done=1.
- Verify with the chain tail bit 5 forced inverted → err_count=1, error=1, done still asserts after 24 shifts.
- Insert 3-cycle cfg_valid gaps between words → shift_en low during gaps, chain contents unchanged, final contents identical to the no-gap run.
- Assert pReset_N low at shift 7 of the load pass → all outputs at reset values immediately; start again → full correct load.
- Pulse start during LOAD and while in DONE → ignored mid-load; from DONE a new load begins with IO_ISOL_N dropping to 0 and err_count cleared.
